// File: rtl/shift_reg_pkg.sv
// Purpose: shared constants and helpers for the parametrised shift register.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shift_reg_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    // Increment that sticks at max instead of wrapping.
    function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned max);
        return (cnt >= max) ? max : cnt + 1;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Purpose: one word-wide stage register with sync clear, enable and 2:1 input mux.
// Latency: 1 cycle from din to q when en is high.
// Backpressure: none; holds its value whenever en is low.
module shift_stage
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sel,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic [WIDTH-1:0] q
);

    // Clear beats enable; sel picks the wraparound feed over the normal one.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= sel ? din1 : din0;
        end
    end

endmodule

// File: rtl/shift_reg_param.sv
// Purpose: DEPTH x WIDTH shift register with rotate, flush, registered tap read and occupancy count.
// Latency: regout after DEPTH shift pulses; tap_out/tap_vld 1 cycle after rd_addr.
// Backpressure: none; once full, new shifts push the oldest word out of the last stage.
module shift_reg_param
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             rot,
    input  logic             clr,
    input  logic [WIDTH-1:0] regin,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] regout,
    output logic [WIDTH-1:0] tap_out,
    output logic             tap_vld,
    output logic [CW-1:0]    count,
    output logic             full
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic             flush;
    logic [WIDTH-1:0] stg [DEPTH];
    logic [CW-1:0]    count_nxt;
    logic             addr_ok;
    logic [WIDTH-1:0] tap_sel;

    assign flush  = rst | clr;
    assign regout = stg[DEPTH-1];

    // Stage 0 selects between the input word and the last stage (rotate);
    // every other stage simply takes its predecessor.
    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_stage
            if (i == 0) begin : g_head
                shift_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk  (clk),
                    .clr  (flush),
                    .en   (we),
                    .sel  (rot),
                    .din0 (regin),
                    .din1 (stg[DEPTH-1]),
                    .q    (stg[0])
                );
            end else begin : g_body
                shift_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk  (clk),
                    .clr  (flush),
                    .en   (we),
                    .sel  (1'b0),
                    .din0 (stg[i-1]),
                    .din1 (stg[i-1]),
                    .q    (stg[i])
                );
            end
        end
    endgenerate

    // Next occupancy: only a plain shift adds a word; rotate keeps the count.
    always_comb begin
        count_nxt = count;
        if (we && !rot) begin
            count_nxt = CW'(sat_inc(32'(count), DEPTH));
        end
    end

    // Tap mux on pre-edge stage contents; addresses past the last stage read as zero.
    always_comb begin
        addr_ok = 32'(rd_addr) < DEPTH;
        tap_sel = '0;
        if (addr_ok) begin
            tap_sel = stg[rd_addr];
        end
    end

    // Counter, full flag and tap register; reset and flush both clear them.
    always_ff @(posedge clk) begin
        if (flush) begin
            count   <= '0;
            full    <= 1'b0;
            tap_out <= '0;
            tap_vld <= 1'b0;
        end else begin
            count   <= count_nxt;
            full    <= (count_nxt == DEPTH_C);
            tap_out <= tap_sel;
            tap_vld <= addr_ok && (32'(rd_addr) < 32'(count));
        end
    end

endmodule

// File: tb/tb_shift_reg_param.sv
// Purpose: scoreboard bench driving a DEPTH=16 and a DEPTH=5 instance with identical stimulus.
// Latency: every cycle's expected outputs are queued at drive time and popped after the edge.
// Backpressure: n/a (bench).
module tb_shift_reg_param;

    typedef struct {
        logic [15:0] ro;
        logic [15:0] to;
        logic        tv;
        logic [4:0]  cnt;
        logic        full;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, we, rot, clr;
    logic [15:0] regin;
    logic [3:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;

    logic [15:0] regout_a, tap_out_a, regout_b, tap_out_b;
    logic        tap_vld_a, full_a, tap_vld_b, full_b;
    logic [4:0]  count_a;
    logic [2:0]  count_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_stg [2][16];
    int          m_cnt [2];
    logic [15:0] m_tap [2];
    logic        m_vld [2];
    logic        m_full[2];

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    shift_reg_param #(.WIDTH(16), .DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .we(we), .rot(rot), .clr(clr), .regin(regin),
        .rd_addr(rd_addr_a), .regout(regout_a), .tap_out(tap_out_a),
        .tap_vld(tap_vld_a), .count(count_a), .full(full_a)
    );

    shift_reg_param #(.WIDTH(16), .DEPTH(5)) dut_b (
        .clk(clk), .rst(rst), .we(we), .rot(rot), .clr(clr), .regin(regin),
        .rd_addr(rd_addr_b), .regout(regout_b), .tap_out(tap_out_b),
        .tap_vld(tap_vld_b), .count(count_b), .full(full_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour of one instance for the inputs currently driven.
    task automatic model_step(input int k, input int d, input int ad);
        exp_t        e;
        logic [15:0] last;
        if (rst || clr) begin
            for (int j = 0; j < 16; j++) m_stg[k][j] = '0;
            m_cnt[k]  = 0;
            m_tap[k]  = '0;
            m_vld[k]  = 1'b0;
            m_full[k] = 1'b0;
        end else begin
            m_tap[k] = (ad < d) ? m_stg[k][ad] : 16'h0;
            m_vld[k] = (ad < d) && (ad < m_cnt[k]);
            if (we) begin
                last = m_stg[k][d-1];
                for (int j = d - 1; j > 0; j--) m_stg[k][j] = m_stg[k][j-1];
                m_stg[k][0] = rot ? last : regin;
                if (!rot && m_cnt[k] < d) m_cnt[k]++;
            end
            m_full[k] = (m_cnt[k] == d);
        end
        e.ro   = m_stg[k][d-1];
        e.to   = m_tap[k];
        e.tv   = m_vld[k];
        e.cnt  = 5'(m_cnt[k]);
        e.full = m_full[k];
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (q0.size() == 0 || q1.size() == 0) begin
            chk("sb_underflow", 32'(q0.size() + q1.size()), 32'd2);
        end else begin
            e = q0.pop_front();
            chk("a_regout", 32'(regout_a),  32'(e.ro));
            chk("a_tap",    32'(tap_out_a), 32'(e.to));
            chk("a_vld",    32'(tap_vld_a), 32'(e.tv));
            chk("a_count",  32'(count_a),   32'(e.cnt));
            chk("a_full",   32'(full_a),    32'(e.full));
            e = q1.pop_front();
            chk("b_regout", 32'(regout_b),  32'(e.ro));
            chk("b_tap",    32'(tap_out_b), 32'(e.to));
            chk("b_vld",    32'(tap_vld_b), 32'(e.tv));
            chk("b_count",  32'(count_b),   32'(e.cnt));
            chk("b_full",   32'(full_b),    32'(e.full));
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic w, input logic ro,
                       input logic [15:0] din, input int a);
        logic [3:0] aa;
        logic [2:0] ab;
        aa = a[3:0];
        ab = a[2:0];
        rst = r; clr = c; we = w; rot = ro; regin = din;
        rd_addr_a = aa;
        rd_addr_b = ab;
        model_step(0, 16, int'(aa));
        model_step(1, 5, int'(ab));
        @(posedge clk);
        #1;
        compare_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 16; j++) m_stg[k][j] = '0;
            m_cnt[k] = 0; m_tap[k] = '0; m_vld[k] = 1'b0; m_full[k] = 1'b0;
        end

        // Reset state
        cyc(1, 0, 0, 0, 16'h0, 0);
        cyc(1, 0, 1, 0, 16'h1234, 0);
        chk("rst_regout", 32'(regout_a), 32'h0);
        chk("rst_count",  32'(count_a),  32'h0);

        // Fill to full with 1..16
        for (int v = 1; v <= 16; v++) cyc(0, 0, 1, 0, 16'(v), 0);
        chk("fill_count",  32'(count_a),  32'd16);
        chk("fill_full",   32'(full_a),   32'd1);
        chk("fill_regout", 32'(regout_a), 32'd1);

        // Rotate: one pulse, then look at stage 0 through the tap
        cyc(0, 0, 1, 1, 16'hFFFF, 0);
        chk("rot1_regout", 32'(regout_a), 32'd2);
        chk("rot1_count",  32'(count_a),  32'd16);
        cyc(0, 0, 0, 1, 16'h0, 0);
        chk("rot1_stage0", 32'(tap_out_a), 32'd1);
        for (int n = 0; n < 15; n++) cyc(0, 0, 1, 1, 16'hBEEF, 0);
        chk("rot16_regout", 32'(regout_a), 32'd1);
        cyc(0, 0, 0, 0, 16'h0, 0);
        chk("rot16_stage0", 32'(tap_out_a), 32'd16);

        // 17th shift pushes the oldest word out
        cyc(0, 0, 1, 0, 16'd17, 0);
        chk("shift17_regout", 32'(regout_a), 32'd2);
        chk("shift17_count",  32'(count_a),  32'd16);

        // Flush beats a concurrent shift
        cyc(0, 1, 1, 0, 16'h55, 0);
        chk("flush_count",  32'(count_a),  32'd0);
        chk("flush_full",   32'(full_a),   32'd0);
        chk("flush_regout", 32'(regout_a), 32'd0);
        cyc(0, 0, 1, 0, 16'h66, 0);
        chk("postflush_count", 32'(count_a), 32'd1);
        cyc(0, 0, 0, 0, 16'h0, 0);
        chk("postflush_tap", 32'(tap_out_a), 32'h66);
        chk("postflush_vld", 32'(tap_vld_a), 32'd1);

        // Tap read after A0..A4
        cyc(0, 1, 0, 0, 16'h0, 0);
        for (int v = 0; v < 5; v++) cyc(0, 0, 1, 0, 16'hA0 + 16'(v), 0);
        cyc(0, 0, 0, 0, 16'h0, 0);
        chk("tap0_dat", 32'(tap_out_a), 32'hA4);
        chk("tap0_vld", 32'(tap_vld_a), 32'd1);
        cyc(0, 0, 0, 0, 16'h0, 4);
        chk("tap4_dat", 32'(tap_out_a), 32'hA0);
        chk("tap4_vld", 32'(tap_vld_a), 32'd1);
        cyc(0, 0, 0, 0, 16'h0, 5);
        chk("tap5_vld", 32'(tap_vld_a), 32'd0);

        // Reset wins over flush and shift mid-stream
        cyc(0, 0, 1, 0, 16'h77, 1);
        cyc(1, 1, 1, 1, 16'h88, 1);
        chk("rstpri_regout", 32'(regout_a),  32'd0);
        chk("rstpri_count",  32'(count_a),   32'd0);
        chk("rstpri_tap",    32'(tap_out_a), 32'd0);
        chk("rstpri_vld",    32'(tap_vld_a), 32'd0);

        // DEPTH=5: exact latency and out-of-range tap address
        for (int v = 1; v <= 5; v++) begin
            cyc(0, 0, 1, 0, 16'hB0 + 16'(v), 0);
            if (v == 4) chk("d5_lat4_regout", 32'(regout_b), 32'd0);
        end
        chk("d5_lat5_regout", 32'(regout_b), 32'hB1);
        chk("d5_full",        32'(full_b),   32'd1);
        cyc(0, 0, 0, 0, 16'h0, 6);
        chk("d5_addr6_tap", 32'(tap_out_b), 32'd0);
        chk("d5_addr6_vld", 32'(tap_vld_b), 32'd0);

        // Random traffic against the scoreboard
        for (int n = 0; n < 300; n++) begin
            cyc(logic'($urandom_range(0, 49) == 0),
                logic'($urandom_range(0, 29) == 0),
                logic'($urandom_range(0, 3) != 0),
                logic'($urandom_range(0, 3) == 0),
                16'($urandom),
                int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
